// File: rtl/pipe_div_pkg.sv
// Shared types and elaboration helpers for the pipelined integer divider.
// Stage widths vary per instance, so the width-independent part of the payload lives here.
package pipe_div_pkg;

    localparam int MIN_DEND_W = 2;
    localparam int MIN_SOR_W  = 1;
    localparam int MIN_TAG_W  = 1;
    localparam int MIN_BPS    = 1;

    // Per-operation sideband carried down the whole pipe next to the datapath.
    typedef struct packed {
        logic q_neg;
        logic r_neg;
        logic dz;
        logic ovf;
    } div_flags_t;

    function automatic int div_latency(input int dend_w, input int bps);
        return dend_w / bps + 2;
    endfunction

    function automatic bit div_params_ok(input int dend_w, input int sor_w, input int bps,
                                         input int signed_en, input int tag_w);
        bit ok;
        ok = (dend_w >= MIN_DEND_W) && (sor_w >= MIN_SOR_W) && (sor_w <= dend_w) &&
             (tag_w >= MIN_TAG_W) && (bps >= MIN_BPS) && (bps <= dend_w) &&
             ((signed_en == 0) || (signed_en == 1));
        if (ok) begin
            ok = ((dend_w % bps) == 0);
        end
        return ok;
    endfunction

endpackage

// File: rtl/pipe_div_stage.sv
// One restoring-division iteration stage: retires BITS_PER_STAGE quotient bits per cycle
// through a combinational chain of compare/subtract sub-steps, then registers the result.
module pipe_div_stage
    import pipe_div_pkg::*;
#(
    parameter int DEND_W         = 16,
    parameter int SOR_W          = 10,
    parameter int BITS_PER_STAGE = 1,
    parameter int TAG_W          = 4
) (
    input  logic              r_clk,
    input  logic              r_rst_n,
    input  logic              en,
    input  logic              in_valid,
    input  logic [SOR_W-1:0]  in_rem,
    input  logic [DEND_W-1:0] in_dq,
    input  logic [SOR_W-1:0]  in_sor,
    input  div_flags_t        in_flags,
    input  logic [TAG_W-1:0]  in_tag,
    output logic              out_valid,
    output logic [SOR_W-1:0]  out_rem,
    output logic [DEND_W-1:0] out_dq,
    output logic [SOR_W-1:0]  out_sor,
    output div_flags_t        out_flags,
    output logic [TAG_W-1:0]  out_tag
);

    // dq holds the unconsumed dividend bits at the top and the quotient bits
    // produced so far at the bottom; each sub-step shifts one across.
    logic [SOR_W-1:0]  rem_c;
    logic [DEND_W-1:0] dq_c;
    logic [SOR_W:0]    trial;
    logic              qbit;

    always_comb begin
        rem_c = in_rem;
        dq_c  = in_dq;
        trial = '0;
        qbit  = 1'b0;
        for (int b = 0; b < BITS_PER_STAGE; b++) begin
            trial = {rem_c, dq_c[DEND_W-1]};
            if (trial >= {1'b0, in_sor}) begin
                trial = trial - {1'b0, in_sor};
                qbit  = 1'b1;
            end else begin
                qbit  = 1'b0;
            end
            rem_c = trial[SOR_W-1:0];
            dq_c  = {dq_c[DEND_W-2:0], qbit};
        end
    end

    always_ff @(posedge r_clk or negedge r_rst_n) begin
        if (!r_rst_n) begin
            out_valid <= 1'b0;
            out_rem   <= '0;
            out_dq    <= '0;
            out_sor   <= '0;
            out_flags <= '0;
            out_tag   <= '0;
        end else if (en) begin
            out_valid <= in_valid;
            if (in_valid) begin
                out_rem   <= rem_c;
                out_dq    <= dq_c;
                out_sor   <= in_sor;
                out_flags <= in_flags;
                out_tag   <= in_tag;
            end
        end
    end

endmodule

// File: rtl/pipe_div_ext.sv
// Fully pipelined signed/unsigned integer divider with tag, dz/ovf flags and a global
// valid/ready stall: input stage, DEND_W/BITS_PER_STAGE iteration stages, output stage.
module pipe_div_ext
    import pipe_div_pkg::*;
#(
    parameter int DEND_W         = 16,
    parameter int SOR_W          = 10,
    parameter int BITS_PER_STAGE = 1,
    parameter int SIGNED_EN      = 1,
    parameter int TAG_W          = 4
) (
    input  logic              r_clk,
    input  logic              r_rst_n,
    input  logic              valid_i,
    output logic              ready_o,
    input  logic              signed_i,
    input  logic [DEND_W-1:0] dividend_i,
    input  logic [SOR_W-1:0]  divisor_i,
    input  logic [TAG_W-1:0]  tag_i,
    output logic              valid_o,
    input  logic              ready_i,
    output logic [DEND_W-1:0] quotient_o,
    output logic [SOR_W-1:0]  remainder_o,
    output logic              dz_o,
    output logic              ovf_o,
    output logic [TAG_W-1:0]  tag_o
);

    if (!div_params_ok(DEND_W, SOR_W, BITS_PER_STAGE, SIGNED_EN, TAG_W)) begin : g_bad_params
        $error("pipe_div_ext: illegal parameter set");
    end

    localparam int N_STAGES = DEND_W / BITS_PER_STAGE;
    localparam logic [DEND_W-1:0] MOST_NEG = {1'b1, {(DEND_W-1){1'b0}}};

    // Handshake: an operation enters when valid_i & ready_o and leaves when
    // valid_o & ready_i; whenever en is low every stage, bubbles included, holds.
    logic en;
    assign en      = ~valid_o | ready_i;
    assign ready_o = en;

    logic              stg_valid [N_STAGES+1];
    logic [SOR_W-1:0]  stg_rem   [N_STAGES+1];
    logic [DEND_W-1:0] stg_dq    [N_STAGES+1];
    logic [SOR_W-1:0]  stg_sor   [N_STAGES+1];
    div_flags_t        stg_flags [N_STAGES+1];
    logic [TAG_W-1:0]  stg_tag   [N_STAGES+1];

    logic              sgn_mode;
    logic              in_dz;
    logic              in_ovf;
    logic              dend_neg;
    logic              sor_neg;
    logic [DEND_W-1:0] dend_mag;
    logic [SOR_W-1:0]  sor_mag;
    div_flags_t        in_flags;

    // A zero divisor runs the raw dividend through unsigned: the restoring chain then
    // yields an all-ones quotient and leaves dividend[SOR_W-1:0] as the remainder.
    always_comb begin
        sgn_mode = (SIGNED_EN != 0) && signed_i;
        in_dz    = (divisor_i == '0);
        dend_neg = sgn_mode && dividend_i[DEND_W-1] && !in_dz;
        sor_neg  = sgn_mode && divisor_i[SOR_W-1];
        in_ovf   = sgn_mode && (dividend_i == MOST_NEG) && (divisor_i == '1);
        dend_mag = dend_neg ? -dividend_i : dividend_i;
        sor_mag  = sor_neg ? -divisor_i : divisor_i;
        in_flags       = '0;
        in_flags.q_neg = dend_neg ^ sor_neg;
        in_flags.r_neg = dend_neg;
        in_flags.dz    = in_dz;
        in_flags.ovf   = in_ovf;
    end

    assign stg_rem[0] = '0;

    always_ff @(posedge r_clk or negedge r_rst_n) begin
        if (!r_rst_n) begin
            stg_valid[0] <= 1'b0;
            stg_dq[0]    <= '0;
            stg_sor[0]   <= '0;
            stg_flags[0] <= '0;
            stg_tag[0]   <= '0;
        end else if (en) begin
            stg_valid[0] <= valid_i;
            if (valid_i) begin
                stg_dq[0]    <= dend_mag;
                stg_sor[0]   <= sor_mag;
                stg_flags[0] <= in_flags;
                stg_tag[0]   <= tag_i;
            end
        end
    end

    for (genvar s = 0; s < N_STAGES; s++) begin : g_stage
        pipe_div_stage #(
            .DEND_W        (DEND_W),
            .SOR_W         (SOR_W),
            .BITS_PER_STAGE(BITS_PER_STAGE),
            .TAG_W         (TAG_W)
        ) u_stage (
            .r_clk    (r_clk),
            .r_rst_n  (r_rst_n),
            .en       (en),
            .in_valid (stg_valid[s]),
            .in_rem   (stg_rem[s]),
            .in_dq    (stg_dq[s]),
            .in_sor   (stg_sor[s]),
            .in_flags (stg_flags[s]),
            .in_tag   (stg_tag[s]),
            .out_valid(stg_valid[s+1]),
            .out_rem  (stg_rem[s+1]),
            .out_dq   (stg_dq[s+1]),
            .out_sor  (stg_sor[s+1]),
            .out_flags(stg_flags[s+1]),
            .out_tag  (stg_tag[s+1])
        );
    end

    logic [DEND_W-1:0] q_fin;
    logic [SOR_W-1:0]  r_fin;

    // Truncating division: quotient carries the XOR sign, remainder the dividend's sign.
    always_comb begin
        q_fin = stg_flags[N_STAGES].q_neg ? -stg_dq[N_STAGES]  : stg_dq[N_STAGES];
        r_fin = stg_flags[N_STAGES].r_neg ? -stg_rem[N_STAGES] : stg_rem[N_STAGES];
    end

    always_ff @(posedge r_clk or negedge r_rst_n) begin
        if (!r_rst_n) begin
            valid_o     <= 1'b0;
            quotient_o  <= '0;
            remainder_o <= '0;
            dz_o        <= 1'b0;
            ovf_o       <= 1'b0;
            tag_o       <= '0;
        end else if (en) begin
            valid_o <= stg_valid[N_STAGES];
            if (stg_valid[N_STAGES]) begin
                quotient_o  <= q_fin;
                remainder_o <= r_fin;
                dz_o        <= stg_flags[N_STAGES].dz;
                ovf_o       <= stg_flags[N_STAGES].ovf;
                tag_o       <= stg_tag[N_STAGES];
            end
        end
    end

endmodule

// File: tb/tb_pipe_div_ext.sv
// Bench for pipe_div_ext: three instances (1, 2 and 4 bits per stage) checked against
// an arithmetic reference model, with directed, streaming/backpressure and reset scenarios.
module tb_pipe_div_ext;

    localparam int NI = 3;

    logic r_clk = 1'b0;
    logic r_rst_n;
    logic [NI-1:0] valid_i_v;
    logic [NI-1:0] ready_i_v;
    logic [NI-1:0] ready_o_v;
    logic [NI-1:0] valid_o_v;
    logic [NI-1:0] dz_v;
    logic [NI-1:0] ovf_v;
    logic [NI-1:0][15:0] quo_v;
    logic [NI-1:0][9:0]  rem_v;
    logic [NI-1:0][3:0]  tag_v;
    logic        signed_i;
    logic [15:0] dividend_i;
    logic [9:0]  divisor_i;
    logic [3:0]  tag_i;

    int total = 0;
    int bad   = 0;
    logic [31:0] exp_q[$];

    always #5 r_clk = ~r_clk;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        localparam int BPS = 1 << g;
        pipe_div_ext #(
            .DEND_W(16), .SOR_W(10), .BITS_PER_STAGE(BPS), .SIGNED_EN(1), .TAG_W(4)
        ) u_dut (
            .r_clk      (r_clk),
            .r_rst_n    (r_rst_n),
            .valid_i    (valid_i_v[g]),
            .ready_o    (ready_o_v[g]),
            .signed_i   (signed_i),
            .dividend_i (dividend_i),
            .divisor_i  (divisor_i),
            .tag_i      (tag_i),
            .valid_o    (valid_o_v[g]),
            .ready_i    (ready_i_v[g]),
            .quotient_o (quo_v[g]),
            .remainder_o(rem_v[g]),
            .dz_o       (dz_v[g]),
            .ovf_o      (ovf_v[g]),
            .tag_o      (tag_v[g])
        );
    end

    function automatic int lat_of(input int k);
        return 16 / (1 << k) + 2;
    endfunction

    function automatic logic [31:0] res_of(input int k);
        return {tag_v[k], ovf_v[k], dz_v[k], rem_v[k], quo_v[k]};
    endfunction

    // Reference: plain integer division, SV '/' and '%' truncate toward zero.
    function automatic logic [31:0] ref_div(input bit sgn, input logic [15:0] a,
                                            input logic [9:0] b, input logic [3:0] t);
        logic [15:0] q;
        logic [9:0]  r;
        bit dz;
        bit ovf;
        int sa;
        int sb;
        dz = 0;
        ovf = 0;
        if (b == 10'd0) begin
            q = 16'hFFFF;
            r = a[9:0];
            dz = 1;
        end else if (sgn) begin
            sa = int'($signed(a));
            sb = int'($signed(b));
            if (sa == -32768 && sb == -1) begin
                q = 16'h8000;
                r = 10'd0;
                ovf = 1;
            end else begin
                q = 16'(sa / sb);
                r = 10'(sa % sb);
            end
        end else begin
            q = 16'(int'(a) / int'(b));
            r = 10'(int'(a) % int'(b));
        end
        return {t, ovf, dz, r, q};
    endfunction

    // Directed operations: {signed, dividend, divisor, quotient, remainder, dz, ovf}
    bit          dir_s [8] = '{0, 1, 1, 1, 0, 1, 1, 0};
    logic [15:0] dir_a [8] = '{16'd1000, 16'hFC18, 16'd1000, 16'hFC18, 16'd1234, 16'd1234, 16'h8000, 16'h8000};
    logic [9:0]  dir_b [8] = '{10'd7, 10'd7, 10'h3F9, 10'h3F9, 10'd0, 10'd0, 10'h3FF, 10'h3FF};
    logic [15:0] dir_q [8] = '{16'd142, 16'hFF72, 16'hFF72, 16'd142, 16'hFFFF, 16'hFFFF, 16'h8000, 16'd32};
    logic [9:0]  dir_r [8] = '{10'd6, 10'h3FA, 10'd6, 10'h3FA, 10'h0D2, 10'h0D2, 10'd0, 10'd32};
    bit          dir_dz[8] = '{0, 0, 0, 0, 1, 1, 0, 0};
    bit          dir_ov[8] = '{0, 0, 0, 0, 0, 0, 1, 0};

    // Issues one operation with ready_i held high and reports latency and result.
    task automatic do_single(input int k, input bit sgn, input logic [15:0] a,
                             input logic [9:0] b, input logic [3:0] t,
                             output int lat, output logic [31:0] res);
        @(posedge r_clk); #1;
        signed_i = sgn;
        dividend_i = a;
        divisor_i = b;
        tag_i = t;
        ready_i_v[k] = 1'b1;
        valid_i_v[k] = 1'b1;
        @(posedge r_clk); #1;
        valid_i_v[k] = 1'b0;
        lat = 1;
        while (!valid_o_v[k] && lat < 100) begin
            @(posedge r_clk); #1;
            lat++;
        end
        res = res_of(k);
    endtask

    task automatic test_reset();
        for (int k = 0; k < NI; k++) begin
            total++;
            if (valid_o_v[k] !== 1'b0) begin
                bad++;
                $display("FAIL reset_valid[%0d]: got %b want 0", k, valid_o_v[k]);
            end
            total++;
            if (res_of(k) !== 32'h0) begin
                bad++;
                $display("FAIL reset_outputs[%0d]: got %h want 00000000", k, res_of(k));
            end
            total++;
            if (ready_o_v[k] !== 1'b1) begin
                bad++;
                $display("FAIL reset_ready[%0d]: got %b want 1", k, ready_o_v[k]);
            end
        end
    endtask

    task automatic test_directed(input int k);
        int lat;
        logic [31:0] res;
        logic [31:0] want;
        logic [3:0] t;
        for (int i = 0; i < 8; i++) begin
            t = 4'(i + 3 * k);
            do_single(k, dir_s[i], dir_a[i], dir_b[i], t, lat, res);
            want = {t, dir_ov[i], dir_dz[i], dir_r[i], dir_q[i]};
            total++;
            if (lat != lat_of(k)) begin
                bad++;
                $display("FAIL directed_latency[%0d.%0d]: got %0d want %0d", k, i, lat, lat_of(k));
            end
            total++;
            if (res !== want) begin
                bad++;
                $display("FAIL directed_result[%0d.%0d]: got %h want %h", k, i, res, want);
            end
        end
    endtask

    task automatic test_back_to_back(input int k);
        int extra;
        exp_q.delete();
        @(posedge r_clk); #1;
        ready_i_v[k] = 1'b1;
        fork
            begin : producer
                int i;
                int cyc;
                bit acc;
                bit sgn;
                int sel;
                logic [15:0] a;
                logic [9:0] b;
                i = 0;
                cyc = 0;
                while (i < 40 && cyc < 1000) begin
                    sel = $urandom_range(0, 9);
                    sgn = 1'($urandom_range(0, 1));
                    a = 16'($urandom);
                    b = 10'($urandom);
                    if (sel == 0) b = 10'd0;
                    else if (sel == 1) begin a = 16'h8000; b = 10'h3FF; end
                    signed_i = sgn;
                    dividend_i = a;
                    divisor_i = b;
                    tag_i = 4'(i);
                    valid_i_v[k] = 1'b1;
                    acc = 0;
                    while (!acc && cyc < 1000) begin
                        @(negedge r_clk);
                        acc = ready_o_v[k];
                        @(posedge r_clk); #1;
                        cyc++;
                    end
                    if (acc) begin
                        exp_q.push_back(ref_div(sgn, a, b, 4'(i)));
                        i++;
                    end
                end
                valid_i_v[k] = 1'b0;
                total++;
                if (i != 40) begin
                    bad++;
                    $display("FAIL b2b_accept[%0d]: got %0d want 40", k, i);
                end
            end
            begin : consumer
                int got;
                int cyc;
                int stall_left;
                bit stall_done;
                logic [31:0] snap;
                logic [31:0] want;
                got = 0;
                cyc = 0;
                stall_left = 0;
                stall_done = 0;
                snap = '0;
                while (got < 40 && cyc < 2000) begin
                    @(negedge r_clk);
                    if (stall_left > 0) begin
                        if (stall_left == 5) snap = res_of(k);
                        else begin
                            total++;
                            if (res_of(k) !== snap) begin
                                bad++;
                                $display("FAIL stall_stable[%0d]: got %h want %h", k, res_of(k), snap);
                            end
                        end
                        total++;
                        if (valid_o_v[k] !== 1'b1 || ready_o_v[k] !== 1'b0) begin
                            bad++;
                            $display("FAIL stall_hs[%0d]: got valid=%b ready=%b want 1 0",
                                     k, valid_o_v[k], ready_o_v[k]);
                        end
                    end else if (valid_o_v[k] && ready_i_v[k]) begin
                        total++;
                        if (exp_q.size() == 0) begin
                            bad++;
                            $display("FAIL b2b_extra[%0d]: got %h want none", k, res_of(k));
                        end else begin
                            want = exp_q.pop_front();
                            if (res_of(k) !== want) begin
                                bad++;
                                $display("FAIL b2b_result[%0d.%0d]: got %h want %h", k, got, res_of(k), want);
                            end
                        end
                        got++;
                    end
                    @(posedge r_clk); #1;
                    cyc++;
                    if (stall_left > 0) stall_left--;
                    else if (got == 10 && !stall_done) begin
                        stall_left = 5;
                        stall_done = 1;
                    end
                    if (stall_left > 0) ready_i_v[k] = 1'b0;
                    else if (stall_done) ready_i_v[k] = ($urandom_range(0, 3) != 0);
                    else ready_i_v[k] = 1'b1;
                end
                ready_i_v[k] = 1'b1;
                total++;
                if (got != 40) begin
                    bad++;
                    $display("FAIL b2b_count[%0d]: got %0d want 40", k, got);
                end
            end
        join
        extra = 0;
        for (int c = 0; c < lat_of(k) + 4; c++) begin
            @(negedge r_clk);
            if (valid_o_v[k]) extra++;
        end
        total++;
        if (extra != 0 || exp_q.size() != 0) begin
            bad++;
            $display("FAIL b2b_drain[%0d]: got extra=%0d left=%0d want 0 0", k, extra, exp_q.size());
        end
    endtask

    task automatic test_reset_mid();
        int cyc;
        int seen;
        int lat;
        logic [31:0] res;
        @(posedge r_clk); #1;
        ready_i_v[0] = 1'b0;
        for (int i = 0; i < 10; i++) begin
            signed_i = 1'($urandom_range(0, 1));
            dividend_i = 16'($urandom);
            divisor_i = 10'($urandom_range(1, 1023));
            tag_i = 4'(i);
            valid_i_v[0] = 1'b1;
            @(posedge r_clk); #1;
        end
        valid_i_v[0] = 1'b0;
        cyc = 0;
        while (!valid_o_v[0] && cyc < 50) begin
            @(posedge r_clk); #1;
            cyc++;
        end
        total++;
        if (valid_o_v[0] !== 1'b1) begin
            bad++;
            $display("FAIL mid_fill: got valid=%b want 1", valid_o_v[0]);
        end
        @(negedge r_clk);
        r_rst_n = 1'b0;
        #1;
        total++;
        if (valid_o_v[0] !== 1'b0 || res_of(0) !== 32'h0) begin
            bad++;
            $display("FAIL mid_reset_drop: got valid=%b out=%h want 0 00000000", valid_o_v[0], res_of(0));
        end
        @(posedge r_clk);
        @(negedge r_clk);
        r_rst_n = 1'b1;
        ready_i_v[0] = 1'b1;
        seen = 0;
        for (int c = 0; c < 30; c++) begin
            @(negedge r_clk);
            if (valid_o_v[0]) seen++;
        end
        total++;
        if (seen != 0) begin
            bad++;
            $display("FAIL mid_ghosts: got %0d want 0", seen);
        end
        do_single(0, 1'b0, 16'd1000, 10'd7, 4'd5, lat, res);
        total++;
        if (lat != 18) begin
            bad++;
            $display("FAIL mid_latency: got %0d want 18", lat);
        end
        total++;
        if (res !== {4'd5, 1'b0, 1'b0, 10'd6, 16'd142}) begin
            bad++;
            $display("FAIL mid_result: got %h want %h", res, {4'd5, 1'b0, 1'b0, 10'd6, 16'd142});
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        r_rst_n = 1'b0;
        valid_i_v = '0;
        ready_i_v = '1;
        signed_i = 1'b0;
        dividend_i = '0;
        divisor_i = '0;
        tag_i = '0;
        repeat (3) @(posedge r_clk);
        @(negedge r_clk);
        test_reset();
        r_rst_n = 1'b1;
        for (int k = 0; k < NI; k++) test_directed(k);
        for (int k = 0; k < NI; k++) test_back_to_back(k);
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pipe_div_ext.md
Name: pipe_div_ext

Overview:
Next-generation fully pipelined integer divider that replaces the fixed unsigned, always-flowing pipe divider in the arithmetic library. It adds per-transaction signed/unsigned mode, selectable radix (bits retired per stage), a sideband tag, divide-by-zero and overflow flags, and valid/ready backpressure with a global stall. It sits between a streaming producer and consumer. It accepts one division per cycle when not stalled.

Parameters:
DEND_W, 16, dividend and quotient width
SOR_W, 10, divisor and remainder width; must satisfy SOR_W <= DEND_W
BITS_PER_STAGE, 1, quotient bits resolved per iteration stage; must divide DEND_W
SIGNED_EN, 1, 0 = signed hardware removed and signed_i ignored (treated as 0)
TAG_W, 4, width of the sideband tag carried alongside each operation

Ports:
r_clk  in  1  clock; all state updates on rising edge
r_rst_n  in  1  reset; asynchronous, active-low
valid_i  in  1  input operation valid
ready_o  out  1  block can accept an input this cycle
signed_i  in  1  1 = two's-complement operands, 0 = unsigned
dividend_i  in  DEND_W  dividend
divisor_i  in  SOR_W  divisor
tag_i  in  TAG_W  opaque tag, returned unchanged
valid_o  out  1  result valid
ready_i  in  1  downstream accepts the result
quotient_o  out  DEND_W  quotient
remainder_o  out  SOR_W  remainder
dz_o  out  1  divisor was zero
ovf_o  out  1  signed quotient overflow
tag_o  out  TAG_W  tag of this result

Behaviour:
- Reset is decided: r_rst_n is asynchronous and active-low; r_clk is the clock. Reset clears all stage valid bits and all output registers (valid_o, dz_o, ovf_o = 0; quotient_o, remainder_o, tag_o = 0). Datapath registers are also cleared.
- Pipeline structure: input stage S0, then N = DEND_W/BITS_PER_STAGE iteration stages, then output stage SO. Latency is L = N+2 cycles from acceptance to valid_o when not stalled. With the defaults, L = 18; with BITS_PER_STAGE=4, L = 6.
- Handshake: define en = ~valid_o | ready_i. ready_o = en (a combinational path from ready_i is permitted). An input is accepted when valid_i & ready_o. When en=0, every stage holds, including bubbles, and bubbles are not collapsed. A result is consumed when valid_o & ready_i. Outputs remain stable while valid_o=1 and ready_i=0.
- S0: captures the operands. In signed mode it registers |dividend| and |divisor|, the quotient sign (signs of the operands XORed), the remainder sign (the dividend sign), the dz flag and the ovf flag.
- Iteration stage: restoring division on an (SOR_W+1)-bit partial remainder, shifting in BITS_PER_STAGE dividend bits MSB-first. Each stage holds one sub-step per bit as a combinational chain.
- SO: negates the quotient and/or the remainder per the stored signs. Rounding truncates toward zero, and a nonzero remainder takes the dividend's sign.
- Divide by zero (divisor == 0, either mode): quotient_o = all ones, remainder_o = dividend_i[SOR_W-1:0], dz_o = 1, ovf_o = 0.
- Signed overflow (dividend = -2^(DEND_W-1), divisor = -1): quotient_o = 2^(DEND_W-1) (the bit pattern of the most negative value), remainder_o = 0, ovf_o = 1.
- Unsigned mode never sets ovf_o.
- Mode switches between back-to-back operations need no bubble; mode, flags and tag travel with each operation.
- Assertion of reset mid-operation discards all in-flight operations immediately, and valid_o = 0 from the reset edge onward.
- Elaboration must fail on an illegal parameter set.

Decomposition:
- Package pipe_div_pkg holds:
  - a stage-payload struct or typedef: partial remainder, quotient bits, remaining dividend bits, divisor magnitude, signs, dz, ovf, tag;
  - an L-computation function;
  - the parameter-legality constants.
- Natural sub-module: pipe_div_stage, a single iteration stage parameterised by BITS_PER_STAGE with an en input. The top instantiates N of them in a generate loop.

Test Plan:
- Unsigned 1000 / 7, defaults -> after 18 cycles: quotient_o = 142, remainder_o = 6, dz_o = 0, ovf_o = 0.
- Signed -1000 / 7 -> quotient_o = 16'hFF72 (-142), remainder_o = 10'h3FA (-6). Signed 1000 / -7 -> 16'hFF72, 6. Signed -1000 / -7 -> 142, 10'h3FA.
- Divide by zero: 1234 / 0 unsigned -> quotient_o = 16'hFFFF, remainder_o = 10'h0D2, dz_o = 1. Repeat with signed_i=1 -> same result.
- Signed overflow -32768 / -1 -> quotient_o = 16'h8000, remainder_o = 0, ovf_o = 1. The same operands unsigned (32768 / 1023) -> quotient_o = 32, remainder_o = 32, ovf_o = 0.
- Backpressure: 40 back-to-back operations with random signed_i and tags 0..39; hold ready_i low for 5 cycles while valid_o = 1. Check: no loss or duplication, tags return in order, outputs stable during the stall, ready_o = 0 during the stall, all results match a reference model. Repeat with BITS_PER_STAGE = 2 and 4 (L = 10 and 6).
- Reset mid-stream: assert r_rst_n low for one cycle with 10 operations in flight -> valid_o drops immediately. None of those operations appear afterward. The first new input produces valid_o exactly L cycles after acceptance.
